// File: rtl/audio_dac_sched.sv
`default_nettype none
// ============================================================================
// Module      : audio_dac_sched
// Description : Stereo playback scheduler for the WM8978 serializer. It fetches
//               one L/R pair per LRC frame from two sources and counts underruns.
//               Optional build macro AUD_MIX_EN: sum both sources when both are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_dac_sched #(
    parameter int UCNT_W = 16
) (
    input  logic              aud_bclk,
    input  logic              sys_rst,
    input  logic              en,
    input  logic              aud_lrc,
    input  logic              tx_done,
    input  logic              src0_valid,
    input  logic [31:0]       src0_left,
    input  logic [31:0]       src0_right,
    output logic              src0_ready,
    input  logic              src1_valid,
    input  logic [31:0]       src1_left,
    input  logic [31:0]       src1_right,
    output logic              src1_ready,
    output logic [31:0]       dac_data,
    output logic              underrun,
    output logic [UCNT_W-1:0] underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state;
    logic [31:0]         r_dac_data;
    logic [31:0]         r_hold_r;
    logic                r_last_grant;
    logic                r_underrun;
    logic [UCNT_W-1:0]   r_underrun_cnt;

    logic                w_fetch;
    logic                w_load_r;
    logic                w_fetching;
    logic                w_any;
    logic                w_both;
    logic                w_sel1;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_lg_upd;
    logic [31:0]         w_left;
    logic [31:0]         w_right;

    assign w_fetch    = tx_done & aud_lrc;
    assign w_load_r   = tx_done & ~aud_lrc;
    // The IDLE->SYNC edge is itself the first fetch of the new playback run.
    assign w_fetching = w_fetch & en & ((r_state == ST_IDLE) | (r_state == ST_RUN));
    assign w_any      = src0_valid | src1_valid;
    assign w_both     = src0_valid & src1_valid;
    assign w_sel1     = src1_valid & (~src0_valid | ~r_last_grant);

`ifdef AUD_MIX_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31])
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return s[31:0];
    endfunction

    assign w_gnt0   = src0_valid & (w_both | ~w_sel1);
    assign w_gnt1   = src1_valid & (w_both | w_sel1);
    assign w_lg_upd = ~w_both;
    assign w_left   = w_both ? sat_add(src0_left, src1_left)
                             : (w_sel1 ? src1_left : src0_left);
    assign w_right  = w_both ? sat_add(src0_right, src1_right)
                             : (w_sel1 ? src1_right : src0_right);
`else
    assign w_gnt0   = src0_valid & ~w_sel1;
    assign w_gnt1   = w_sel1;
    assign w_lg_upd = 1'b1;
    assign w_left   = w_sel1 ? src1_left  : src0_left;
    assign w_right  = w_sel1 ? src1_right : src0_right;
`endif

    assign src0_ready   = w_fetching & w_gnt0;
    assign src1_ready   = w_fetching & w_gnt1;
    assign dac_data     = r_dac_data;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

    always_ff @(posedge aud_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_dac_data     <= 32'd0;
            r_hold_r       <= 32'd0;
            r_last_grant   <= 1'b1;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_underrun <= 1'b0;

            if (w_fetching) begin
                if (w_any) begin
                    r_dac_data <= w_left;
                    r_hold_r   <= w_right;
                    if (w_lg_upd)
                        r_last_grant <= w_sel1;
                end else begin
                    r_dac_data <= 32'd0;
                    r_hold_r   <= 32'd0;
                    r_underrun <= 1'b1;
                    if (r_underrun_cnt != {UCNT_W{1'b1}})
                        r_underrun_cnt <= r_underrun_cnt + UCNT_W'(1);
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fetch && en)
                        r_state <= ST_SYNC;
                end
                ST_SYNC: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_fetch && !en) begin
                        r_state    <= ST_IDLE;
                        r_dac_data <= 32'd0;
                        r_hold_r   <= 32'd0;
                    end else if (w_load_r) begin
                        r_dac_data <= r_hold_r;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_dac_sched
// Description : Scoreboard bench for audio_dac_sched; expected words are queued
//               per tx_done pulse and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_dac_sched;

    typedef struct {
        logic [31:0] dac;
        logic        r0;
        logic        r1;
        logic        ur;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    logic        aud_bclk = 1'b0;
    logic        sys_rst  = 1'b1;
    logic        en       = 1'b0;
    logic        aud_lrc  = 1'b0;
    logic        tx_done  = 1'b0;
    logic        src0_valid = 1'b0;
    logic [31:0] src0_left  = 32'd0;
    logic [31:0] src0_right = 32'd0;
    logic        src1_valid = 1'b0;
    logic [31:0] src1_left  = 32'd0;
    logic [31:0] src1_right = 32'd0;
    logic        src0_ready, src1_ready, src0_ready2, src1_ready2;
    logic [31:0] dac_data, dac_data2;
    logic        underrun, underrun2;
    logic [15:0] underrun_cnt;
    logic [1:0]  underrun_cnt2;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 aud_bclk = ~aud_bclk;

    audio_dac_sched #(.UCNT_W(16)) dut (
        .aud_bclk(aud_bclk), .sys_rst(sys_rst), .en(en), .aud_lrc(aud_lrc),
        .tx_done(tx_done),
        .src0_valid(src0_valid), .src0_left(src0_left), .src0_right(src0_right),
        .src0_ready(src0_ready),
        .src1_valid(src1_valid), .src1_left(src1_left), .src1_right(src1_right),
        .src1_ready(src1_ready),
        .dac_data(dac_data), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    audio_dac_sched #(.UCNT_W(2)) dut2 (
        .aud_bclk(aud_bclk), .sys_rst(sys_rst), .en(en), .aud_lrc(aud_lrc),
        .tx_done(tx_done),
        .src0_valid(src0_valid), .src0_left(src0_left), .src0_right(src0_right),
        .src0_ready(src0_ready2),
        .src1_valid(src1_valid), .src1_left(src1_left), .src1_right(src1_right),
        .src1_ready(src1_ready2),
        .dac_data(dac_data2), .underrun(underrun2), .underrun_cnt(underrun_cnt2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One half-frame: LRC level, optional mid-half en change, then a tx_done pulse.
    task automatic half(input logic lrc, input logic en_v, input logic [31:0] dac,
                        input logic r0, input logic r1, input logic ur,
                        input logic [15:0] cnt, input logic [1:0] cnt2);
        exp_t e;
        e.dac = dac; e.r0 = r0; e.r1 = r1; e.ur = ur; e.cnt = cnt; e.cnt2 = cnt2;
        aud_lrc = lrc;
        repeat (12) @(posedge aud_bclk);
        #1 en = en_v;
        repeat (22) @(posedge aud_bclk);
        #1;
        exp_q.push_back(e);
        tx_done = 1'b1;
        @(posedge aud_bclk);
        #1 tx_done = 1'b0;
        repeat (2) @(posedge aud_bclk);
        #1;
    endtask

    task automatic set_src(input logic v0, input logic [31:0] l0, input logic [31:0] r0,
                           input logic v1, input logic [31:0] l1, input logic [31:0] r1);
        src0_valid = v0; src0_left = l0; src0_right = r0;
        src1_valid = v1; src1_left = l1; src1_right = r1;
    endtask

    // Monitor: readies are captured during the tx_done cycle, registered outputs one cycle later.
    initial begin
        logic cap_r0, cap_r1, pend;
        exp_t e;
        pend = 1'b0; cap_r0 = 1'b0; cap_r1 = 1'b0;
        forever begin
            @(negedge aud_bclk);
            if (pend) begin
                pend = 1'b0;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_output: got dac %h with empty queue", dac_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("dac_data", dac_data, e.dac);
                    chk("src0_ready", {31'd0, cap_r0}, {31'd0, e.r0});
                    chk("src1_ready", {31'd0, cap_r1}, {31'd0, e.r1});
                    chk("underrun", {31'd0, underrun}, {31'd0, e.ur});
                    chk("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, e.cnt});
                    chk("underrun_cnt_w2", {30'd0, underrun_cnt2}, {30'd0, e.cnt2});
                end
            end
            if (tx_done) begin
                cap_r0 = src0_ready;
                cap_r1 = src1_ready;
                pend   = 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge aud_bclk);
        #1;
        chk("rst_dac_data", dac_data, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        chk("rst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        chk("rst_ready", {30'd0, src1_ready, src0_ready}, 32'd0);
        sys_rst = 1'b0;
        @(posedge aud_bclk); #1;

        // Single source: silent frame 0, then L/R from src0.
        set_src(1'b1, 32'h1111_0000, 32'h2222_0000, 1'b0, 32'h0, 32'h0);
        half(1'b0, 1'b1, 32'h0000_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 0, 0);
        half(1'b0, 1'b1, 32'h2222_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 0, 0);
        half(1'b0, 1'b1, 32'h2222_0000, 0, 0, 0, 0, 0);

        // Both sources valid; last grant was src0.
        set_src(1'b1, 32'h1111_0000, 32'h2222_0000, 1'b1, 32'h3333_0000, 32'h4444_0000);
`ifdef AUD_MIX_EN
        for (int i = 0; i < 3; i++) begin
            half(1'b1, 1'b1, 32'h4444_0000, 1, 1, 0, 0, 0);
            half(1'b0, 1'b1, 32'h6666_0000, 0, 0, 0, 0, 0);
        end
`else
        half(1'b1, 1'b1, 32'h3333_0000, 0, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h4444_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 0, 0);
        half(1'b0, 1'b1, 32'h2222_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h3333_0000, 0, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h4444_0000, 0, 0, 0, 0, 0);
`endif

        // Underruns: five fetches with no source; the 2-bit counter saturates at 3.
        set_src(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        half(1'b1, 1'b1, 32'h0, 0, 0, 1, 1, 1);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 1, 1);
        half(1'b1, 1'b1, 32'h0, 0, 0, 1, 2, 2);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 2, 2);
        half(1'b1, 1'b1, 32'h0, 0, 0, 1, 3, 3);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 3, 3);
        half(1'b1, 1'b1, 32'h0, 0, 0, 1, 4, 3);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 4, 3);
        half(1'b1, 1'b1, 32'h0, 0, 0, 1, 5, 3);

        // en dropped mid-left-half: right half still plays, then back to IDLE.
        set_src(1'b1, 32'h1111_0000, 32'h2222_0000, 1'b0, 32'h0, 32'h0);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 5, 3);
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 5, 3);
        half(1'b0, 1'b0, 32'h2222_0000, 0, 0, 0, 5, 3);
        half(1'b1, 1'b0, 32'h0, 0, 0, 0, 5, 3);
        half(1'b0, 1'b0, 32'h0, 0, 0, 0, 5, 3);
        half(1'b1, 1'b0, 32'h0, 0, 0, 0, 5, 3);

        // Re-enable, then reset mid-frame while in RUN.
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 5, 3);
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 5, 3);
        half(1'b0, 1'b1, 32'h2222_0000, 0, 0, 0, 5, 3);
        aud_lrc = 1'b1;
        repeat (10) @(posedge aud_bclk);
        #1 sys_rst = 1'b1;
        #1;
        chk("midrst_dac_data", dac_data, 32'd0);
        chk("midrst_underrun_cnt", {16'd0, underrun_cnt}, 32'd0);
        chk("midrst_underrun_cnt_w2", {30'd0, underrun_cnt2}, 32'd0);
        repeat (2) @(posedge aud_bclk);
        #1 sys_rst = 1'b0;
        repeat (20) @(posedge aud_bclk);
        #1;

        // After reset last_grant is 1, so src0 wins the first tie.
        set_src(1'b1, 32'h1111_0000, 32'h2222_0000, 1'b1, 32'h3333_0000, 32'h4444_0000);
        half(1'b0, 1'b1, 32'h0, 0, 0, 0, 0, 0);
`ifdef AUD_MIX_EN
        half(1'b1, 1'b1, 32'h4444_0000, 1, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h6666_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h4444_0000, 1, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h6666_0000, 0, 0, 0, 0, 0);
        // Saturating sums.
        set_src(1'b1, 32'h7000_0000, 32'hFFFF_FFFF, 1'b1, 32'h2000_0000, 32'h0000_0001);
        half(1'b1, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h0000_0000, 0, 0, 0, 0, 0);
        set_src(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
        half(1'b1, 1'b1, 32'h0000_0000, 1, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h8000_0000, 0, 0, 0, 0, 0);
`else
        half(1'b1, 1'b1, 32'h1111_0000, 1, 0, 0, 0, 0);
        half(1'b0, 1'b1, 32'h2222_0000, 0, 0, 0, 0, 0);
        half(1'b1, 1'b1, 32'h3333_0000, 0, 1, 0, 0, 0);
        half(1'b0, 1'b1, 32'h4444_0000, 0, 0, 0, 0, 0);
`endif

        repeat (3) @(posedge aud_bclk);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_dac_sched.md
# audio_dac_sched

Stereo playback scheduler that sits in front of the WM8978 DAC serializer (`audio_send`), in the `aud_bclk` domain. It arbitrates between two stereo sample sources and fetches one left/right pair per LRC frame. It presents `dac_data` so the serializer loads left on the left half-frame and right on the right half-frame, using the serializer's `tx_done` pulse as the schedule tick. It also flags underruns when no source has a sample ready at the frame boundary.

## Interface
- `UCNT_W`, 16: width of the saturating underrun counter.
- `aud_bclk  in  1`: bit clock, sole clock.
- `sys_rst  in  1`: asynchronous, active-high reset.
- `en  in  1`: playback enable; sampled only at frame boundaries.
- `aud_lrc  in  1`: WM8978 LRC; 0 = left half-frame, 1 = right half-frame.
- `tx_done  in  1`: one-cycle pulse from the serializer after a 32-bit word has been shifted out.
- `src0_valid  in  1`, `src0_left  in  32`, `src0_right  in  32`, `src0_ready  out  1`: source 0 stereo pair handshake.
- `src1_valid  in  1`, `src1_left  in  32`, `src1_right  in  32`, `src1_ready  out  1`: source 1 stereo pair handshake.
- `dac_data  out  32`: word for the serializer to load at the next LRC edge.
- `underrun  out  1`: one-cycle pulse when a frame fetch finds no valid source.
- `underrun_cnt  out  UCNT_W`: saturating underrun count.

## Operation
- Definitions:
  - `fetch = tx_done & aud_lrc`: end of the right half, which is the frame boundary.
  - `load_r = tx_done & ~aud_lrc`: end of the left half.
- FSM states are IDLE, SYNC and RUN.
  - IDLE: `dac_data` = 0; no handshakes. Go to SYNC on `fetch` with `en`=1.
  - SYNC: performs the first fetch immediately on entry, on the same `fetch` edge. Then go to RUN.
  - RUN: on `load_r`, `dac_data` <= held right sample. On `fetch`, fetch the next pair.
  - RUN with `en`=0 at a `fetch`: go to IDLE, `dac_data` <= 0, no handshake.
- Fetch:
  - Grant is round-robin between valid sources.
  - A lone valid source is always granted.
  - When both sources are valid, grant the source not granted last. The `last_grant` register resets to 1, so src0 wins the first tie.
  - `srcN_ready` = `fetch` & fetching-state & grant to N. It is combinational, and a transfer occurs when `valid` & `ready` are high at the same posedge.
  - On transfer: `dac_data` <= granted left sample; right sample goes to the internal `hold_r`; `last_grant` updates.
  - No valid source: `dac_data` <= 0 and `hold_r` <= 0. Pulse `underrun`; `underrun_cnt` += 1, saturating at all-ones.
- Sources must hold `valid` and data stable until accepted. Sources may deassert `valid` only after a transfer.
- `en` only affects behaviour at `fetch` edges. A half-sent frame always completes with its loaded data.
- A `tx_done` pulse arriving while in IDLE is ignored, except as the IDLE→SYNC trigger.

## Timing
- Reset values (immediate on `sys_rst` high):
  - `dac_data`=0, `underrun`=0, `underrun_cnt`=0.
  - `hold_r`=0, `last_grant`=1, state=IDLE.
  - `srcN_ready`=0.
- Latency:
  - `dac_data` is updated on the posedge where `tx_done` is high.
  - The serializer samples it at the next LRC edge, at least 2 `aud_bclk` later.
  - This requires every half-frame to be at least 34 `aud_bclk` long.
- Frame 0 after enable is always silent. Source data appears starting with the left half of the frame after the first `fetch`.
- Reset asserted mid-frame: all state clears; the next enable resynchronises from IDLE.
- `tx_done` and a change in `en` in the same cycle: the fetch uses the `en` value sampled in that cycle.

## Configuration
- `AUD_MIX_EN` defined: when both sources are valid at a fetch, both `ready` signals assert.
  - Output is the per-channel signed two's-complement sum of the two sources.
  - The sum saturates to 0x7FFFFFFF / 0x80000000.
  - `last_grant` is unchanged in that case. A lone valid source behaves as without the macro.
- `AUD_MIX_EN` undefined: round-robin arbitration as above; no adder logic.

## Test plan
- Reset, then `en`=1, src0 holding L=0x11110000, R=0x22220000 →
  - first frame `dac_data`=0;
  - next frame `dac_data`=0x11110000 at the left `fetch`, then 0x22220000 at `load_r`;
  - `src0_ready` is a 1-cycle pulse on `fetch`.
- Both sources valid with distinct data (mix off) → grants alternate src0, src1, src0 over 3 frames, with matching `dac_data` sequence.
- No source valid for 3 frames in RUN → `dac_data`=0 both halves, 3 `underrun` pulses, `underrun_cnt`=3. With `UCNT_W`=2 and 5 underruns → count holds at 3.
- `en` dropped mid-left-half → current frame's right half still outputs `hold_r`; at the next `fetch` state=IDLE, `dac_data`=0, no ready pulses.
- `AUD_MIX_EN` with src0 L=0x70000000 and src1 L=0x20000000 → `dac_data`=0x7FFFFFFF. With L=-1 and L=1 → 0. Both readies pulse together.
- `sys_rst` pulsed mid-frame while in RUN → outputs zero immediately; a re-enable resumes with a silent first frame.
